// File: rtl/regset_sequencer.sv
// Register-file bus sequencer: round-robin arbitration between two requesters, then DRIVE/STROBE/DONE.
// Optional: define REGSET_SEQ_SELF_MOV_SKIP_EN to turn a MOV with rd==rs into a no-op.
module regset_sequencer #(
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic              i_reqA,
  input  logic [1:0]        i_opA,
  input  logic [1:0]        i_rdA,
  input  logic [1:0]        i_rsA,
  input  logic [DATA_W-1:0] i_immA,
  output logic              o_ackA,
  input  logic              i_reqB,
  input  logic [1:0]        i_opB,
  input  logic [1:0]        i_rdB,
  input  logic [1:0]        i_rsB,
  input  logic [DATA_W-1:0] i_immB,
  output logic              o_ackB,
  output logic [1:0]        o_writeSel,
  output logic              o_we,
  output logic [1:0]        o_outSel,
  output logic              o_noe,
  output logic              o_immNoe,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_capture,
  output logic              o_busy
);
  localparam int         SETTLE   = (SETTLE_CYC < 1 || SETTLE_CYC > 3) ? 1 : SETTLE_CYC;
  localparam logic [1:0] LAST_CNT = 2'(SETTLE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] OP_MOV = 2'd0;
  localparam logic [1:0] OP_LDI = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  logic [1:0]        r_state, r_cnt, r_op, r_rd;
  logic              r_grantB, r_prioB;
  logic              r_ackA, r_ackB, r_we, r_noe, r_immNoe, r_capture, r_busy;
  logic [1:0]        r_writeSel, r_outSel;
  logic [DATA_W-1:0] r_imm;

  logic              w_grantA, w_grantB, w_skip;
  logic [1:0]        w_op, w_rd, w_rs;
  logic [DATA_W-1:0] w_imm;

  // r_prioB set means B wins a tie on the next arbitration
  always_comb begin
    w_grantA = i_reqA && (!i_reqB || !r_prioB);
    w_grantB = i_reqB && !w_grantA;
    w_op     = w_grantB ? i_opB  : i_opA;
    w_rd     = w_grantB ? i_rdB  : i_rdA;
    w_rs     = w_grantB ? i_rsB  : i_rsA;
    w_imm    = w_grantB ? i_immB : i_immA;
    w_skip   = (w_op == OP_NOP);
`ifdef REGSET_SEQ_SELF_MOV_SKIP_EN
    if (w_op == OP_MOV && w_rd == w_rs) w_skip = 1'b1;
`endif
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_op       <= OP_NOP;
      r_rd       <= 2'd0;
      r_grantB   <= 1'b0;
      r_prioB    <= 1'b0;
      r_ackA     <= 1'b0;
      r_ackB     <= 1'b0;
      r_we       <= 1'b0;
      r_noe      <= 1'b1;
      r_immNoe   <= 1'b1;
      r_capture  <= 1'b0;
      r_busy     <= 1'b0;
      r_writeSel <= 2'd0;
      r_outSel   <= 2'd0;
      r_imm      <= '0;
    end else begin
      r_ackA <= 1'b0;
      r_ackB <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantA || w_grantB) begin
            r_grantB <= w_grantB;
            r_prioB  <= w_grantA;
            r_op     <= w_op;
            r_rd     <= w_rd;
            r_imm    <= w_imm;
            r_cnt    <= 2'd0;
            r_busy   <= 1'b1;
            if (w_skip) begin
              // No bus activity: complete on the next cycle
              r_ackA  <= w_grantA;
              r_ackB  <= w_grantB;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRIVE;
              if (w_op == OP_LDI) begin
                r_immNoe <= 1'b0;
              end else begin
                r_noe    <= 1'b0;
                r_outSel <= w_rs;
              end
            end
          end
        end
        S_DRIVE: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= S_STROBE;
            if (r_op == OP_RD) begin
              r_capture <= 1'b1;
            end else begin
              r_we       <= 1'b1;
              r_writeSel <= r_rd;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_STROBE: begin
          r_we      <= 1'b0;
          r_capture <= 1'b0;
          r_noe     <= 1'b1;
          r_immNoe  <= 1'b1;
          r_ackA    <= !r_grantB;
          r_ackB    <= r_grantB;
          r_state   <= S_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ackA     = r_ackA;
  assign o_ackB     = r_ackB;
  assign o_writeSel = r_writeSel;
  assign o_we       = r_we;
  assign o_outSel   = r_outSel;
  assign o_noe      = r_noe;
  assign o_immNoe   = r_immNoe;
  assign o_imm      = r_imm;
  assign o_capture  = r_capture;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_regset_sequencer.sv
// Bench for regset_sequencer: command-level timeline model, a 4-entry register file on the bus, directed vectors.
module tb_regset_sequencer;
  localparam int SETTLE = 1;
  localparam logic [1:0] MOV = 2'd0, LDI = 2'd1, RD = 2'd2, NOP = 2'd3;
`ifdef REGSET_SEQ_SELF_MOV_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqA, reqB;
  logic [1:0]  opA, rdA, rsA, opB, rdB, rsB;
  logic [15:0] immA, immB;
  logic        o_ackA, o_ackB, o_we, o_noe, o_immNoe, o_capture, o_busy;
  logic [1:0]  o_writeSel, o_outSel;
  logic [15:0] o_imm;

  regset_sequencer #(.DATA_W(16), .SETTLE_CYC(SETTLE)) dut (
    .i_clk(clk), .i_nReset(rst_n),
    .i_reqA(reqA), .i_opA(opA), .i_rdA(rdA), .i_rsA(rsA), .i_immA(immA), .o_ackA(o_ackA),
    .i_reqB(reqB), .i_opB(opB), .i_rdB(rdB), .i_rsB(rsB), .i_immB(immB), .o_ackB(o_ackB),
    .o_writeSel(o_writeSel), .o_we(o_we), .o_outSel(o_outSel), .o_noe(o_noe),
    .o_immNoe(o_immNoe), .o_imm(o_imm), .o_capture(o_capture), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file sitting on the bus
  logic [15:0] rf [4];
  logic [15:0] bus;
  bit          rf_ld;
  assign bus = !o_noe ? rf[o_outSel] : (!o_immNoe ? o_imm : 16'h0000);
  always @(posedge clk) begin
    if (rf_ld) begin
      rf[0] <= 16'h0A0A; rf[1] <= 16'h1111; rf[2] <= 16'h2222; rf[3] <= 16'h3333;
    end else if (o_we) begin
      rf[o_writeSel] <= bus;
    end
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected per-cycle outputs, expanded from each granted command
  typedef struct {
    bit noe, immNoe, we, cap, ackA, ackB, busy, commit;
    logic [1:0] op, rd, rs;
    logic [15:0] imm;
  } exp_t;
  exp_t        q[$];
  exp_t        idle_e;
  logic [15:0] exp_rf [4];
  bit          prioB;

  task automatic expand(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [15:0] imm, input bit pb);
    exp_t e;
    bit   skip;
    skip = (op == NOP) || (SKIP && op == MOV && rd == rs);
    e = idle_e;
    e.op = op; e.rd = rd; e.rs = rs; e.imm = imm; e.busy = 1'b1;
    if (!skip) begin
      e.noe = (op == LDI); e.immNoe = (op != LDI);
      for (int i = 0; i < SETTLE; i++) q.push_back(e);
      e.we = (op != RD); e.cap = (op == RD); e.commit = (op != RD);
      q.push_back(e);
      e.we = 1'b0; e.cap = 1'b0; e.commit = 1'b0; e.noe = 1'b1; e.immNoe = 1'b1;
    end
    e.ackA = !pb; e.ackB = pb;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    bit   gB;
    idle_e = '{noe: 1'b1, immNoe: 1'b1, default: '0};
    exp_rf[0] = 16'h0A0A; exp_rf[1] = 16'h1111; exp_rf[2] = 16'h2222; exp_rf[3] = 16'h3333;
    prioB = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        prioB = 1'b0;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        if (e.commit) exp_rf[e.rd] = (e.op == LDI) ? e.imm : exp_rf[e.rs];
      end else if (reqA || reqB) begin
        gB = reqB && (!reqA || prioB);
        prioB = !gB;
        if (gB) expand(opB, rdB, rsB, immB, 1'b1);
        else    expand(opA, rdA, rsA, immA, 1'b0);
      end
    end
  end

  bit          ackq[$];
  int          ackc[$];
  logic [15:0] last_cap;

  // Per-cycle comparison against the model
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      e = (rst_n && q.size() != 0) ? q[0] : idle_e;
      ok = (o_noe == e.noe) && (o_immNoe == e.immNoe) && (o_we == e.we) && (o_capture == e.cap) &&
           (o_ackA == e.ackA) && (o_ackB == e.ackB) && (o_busy == e.busy) &&
           (e.noe || o_outSel == e.rs) && (!e.we || o_writeSel == e.rd) &&
           (e.immNoe || o_imm == e.imm);
      chk(ok, "cycle_outputs",
          {5'b0, o_noe, o_immNoe, o_we, o_capture, o_ackA, o_ackB, o_busy, o_outSel, o_writeSel, o_imm},
          {5'b0, e.noe, e.immNoe, e.we, e.cap, e.ackA, e.ackB, e.busy, e.rs, e.rd, e.imm});
      chk(!(!o_noe && !o_immNoe), "driver_exclusive", {30'b0, o_noe, o_immNoe}, 32'h1);
      if (o_we) chk(o_noe ^ o_immNoe, "we_single_driver", {30'b0, o_noe, o_immNoe}, 32'h1);
      if (o_capture) begin
        last_cap = bus;
        chk(bus == exp_rf[e.rs], "capture_data", {16'b0, bus}, {16'b0, exp_rf[e.rs]});
      end
      if (o_ackA) begin ackq.push_back(1'b0); ackc.push_back(cyc); end
      if (o_ackB) begin ackq.push_back(1'b1); ackc.push_back(cyc); end
    end
  end

  task automatic issue(input bit port, input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [15:0] imm, output int lat);
    int start;
    bit got;
    @(posedge clk); #1;
    if (!port) begin opA = op; rdA = rd; rsA = rs; immA = imm; reqA = 1'b1; end
    else       begin opB = op; rdB = rd; rsB = rs; immB = imm; reqB = 1'b1; end
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? o_ackB : o_ackA) got = 1'b1;
    end
    lat = got ? cyc - start : -1;
    if (!got) chk(1'b0, "ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (!port) reqA = 1'b0; else reqB = 1'b0;
  endtask

  initial begin
    int lat, la1, la2, lb1, lb2, n;
    bit got;
    rst_n = 1'b0; rf_ld = 1'b1;
    reqA = 1'b0; opA = NOP; rdA = 2'd0; rsA = 2'd0; immA = 16'h0;
    reqB = 1'b0; opB = NOP; rdB = 2'd0; rsB = 2'd0; immB = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk({o_noe, o_immNoe, o_we, o_capture, o_ackA, o_ackB, o_busy, o_writeSel, o_outSel, o_imm} ==
        {7'b1100000, 4'b0, 16'h0}, "reset_values",
        {5'b0, o_noe, o_immNoe, o_we, o_capture, o_ackA, o_ackB, o_busy, o_writeSel, o_outSel, o_imm},
        {5'b0, 7'b1100000, 4'b0, 16'h0});
    @(negedge clk);
    rst_n = 1'b1; rf_ld = 1'b0;
    repeat (3) @(posedge clk);

    issue(1'b0, LDI, 2'd2, 2'd0, 16'h1234, lat);
    chk(lat == 3, "ldi_latency", lat, 3);
    repeat (2) @(posedge clk); #1;
    chk(rf[2] == 16'h1234, "ldi_r2", {16'b0, rf[2]}, 32'h1234);
    chk(exp_rf[2] == 16'h1234, "model_r2", {16'b0, exp_rf[2]}, 32'h1234);

    issue(1'b1, MOV, 2'd3, 2'd2, 16'h0, lat);
    chk(lat == 3, "mov_latency", lat, 3);
    chk(ackq[ackq.size()-1] == 1'b1, "mov_ack_port", {31'b0, ackq[ackq.size()-1]}, 32'h1);
    repeat (2) @(posedge clk); #1;
    chk(rf[3] == 16'h1234, "mov_r3", {16'b0, rf[3]}, 32'h1234);

    ackq.delete(); ackc.delete();
    fork
      begin issue(1'b0, LDI, 2'd0, 2'd0, 16'hA001, la1); issue(1'b0, LDI, 2'd0, 2'd0, 16'hA002, la2); end
      begin issue(1'b1, MOV, 2'd1, 2'd0, 16'h0, lb1);    issue(1'b1, RD,  2'd0, 2'd0, 16'h0, lb2); end
    join
    chk(ackq.size() == 4, "rr_ack_count", ackq.size(), 4);
    if (ackq.size() == 4) begin
      chk({ackq[0], ackq[1], ackq[2], ackq[3]} == 4'b0101, "rr_order",
          {28'b0, ackq[0], ackq[1], ackq[2], ackq[3]}, 32'h5);
      for (int i = 1; i < 4; i++)
        chk(ackc[i] - ackc[i-1] == 4, "rr_ack_spacing", ackc[i] - ackc[i-1], 4);
    end
    chk(rf[0] == 16'hA002, "rr_r0", {16'b0, rf[0]}, 32'hA002);
    chk(rf[1] == 16'hA001, "rr_r1", {16'b0, rf[1]}, 32'hA001);
    chk(last_cap == 16'hA002, "rr_rd_capture", {16'b0, last_cap}, 32'hA002);

    issue(1'b0, RD, 2'd0, 2'd3, 16'h0, lat);
    chk(lat == 3, "rd_latency", lat, 3);
    chk(last_cap == 16'h1234, "rd_capture", {16'b0, last_cap}, 32'h1234);

    // Reset asserted during STROBE of an LDI
    @(posedge clk); #1;
    opA = LDI; rdA = 2'd2; rsA = 2'd0; immA = 16'hBEEF; reqA = 1'b1;
    n = ackq.size();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_we) got = 1'b1;
    end
    chk(got, "strobe_reached", {31'b0, got}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk({o_noe, o_immNoe, o_we, o_capture, o_busy, o_writeSel, o_imm} == {5'b11000, 2'b0, 16'h0},
        "async_reset", {9'b0, o_noe, o_immNoe, o_we, o_capture, o_busy, o_writeSel, o_imm},
        {9'b0, 5'b11000, 2'b0, 16'h0});
    reqA = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk(ackq.size() == n, "no_ack_after_reset", ackq.size(), n);
    chk(rf[2] == 16'h1234, "write_lost", {16'b0, rf[2]}, 32'h1234);
    issue(1'b0, LDI, 2'd2, 2'd0, 16'h0F0F, lat);
    chk(lat == 3, "post_reset_latency", lat, 3);
    repeat (2) @(posedge clk); #1;
    chk(rf[2] == 16'h0F0F, "post_reset_r2", {16'b0, rf[2]}, 32'h0F0F);

    issue(1'b1, MOV, 2'd1, 2'd1, 16'h0, lat);
    chk(lat == (SKIP ? 1 : 3), "self_move_latency", lat, SKIP ? 1 : 3);
    repeat (2) @(posedge clk); #1;
    chk(rf[1] == 16'hA001, "self_move_r1", {16'b0, rf[1]}, 32'hA001);

    issue(1'b0, NOP, 2'd0, 2'd0, 16'h0, lat);
    chk(lat == 1, "nop_latency", lat, 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
